// File: rtl/fft_bitrev_deser.sv
// Bit-reversed FFT output deserializer: gathers N/2 sample pairs per frame into a
// ping-pong bank in natural order and presents each full bank as a parallel vector.
module fft_bitrev_deser #(
  parameter int N   = 8,
  parameter int DW  = 16,   // width of each real/imag component; a sample is {re, im}
  parameter int FCW = 16,   // frame counter width
  localparam int LOG2N     = $clog2(N),
  localparam int NUM_PAIRS = N / 2,
  localparam int KW        = $clog2(N / 2),
  localparam int SW        = 2 * DW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SW-1:0]          in_x,
  input  logic [SW-1:0]          in_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0][SW-1:0]   fft_out,
  output logic [FCW-1:0]         frame_cnt
);

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} bank_st_e;

  localparam logic [KW-1:0] KLAST = KW'(NUM_PAIRS - 1);

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    for (int i = 0; i < LOG2N; i++) bitrev[i] = a[LOG2N-1-i];
  endfunction

  bank_st_e                  st_q [2];
  bank_st_e                  st_d [2];
  logic [KW-1:0]             k_q, k_d;
  logic                      wr_q, wr_d, rd_q, rd_d;
  logic [FCW-1:0]            cnt_q, cnt_d;
  logic                      en_q;
  logic [1:0][N-1:0][SW-1:0] bank_q;
  logic                      acc, rel;
  logic [LOG2N-1:0]          addr_x, addr_y;

  // en_q holds in_ready low during reset and for the edge that ends it
  assign in_ready  = en_q & (st_q[wr_q] == FILLING);
  assign out_valid = (st_q[rd_q] == FULL);
  assign fft_out   = out_valid ? bank_q[rd_q] : '0;
  assign frame_cnt = cnt_q;

  assign acc    = in_valid & in_ready;
  assign rel    = out_valid & out_ready;
  assign addr_x = bitrev({k_q, 1'b0});
  assign addr_y = bitrev({k_q, 1'b1});

  always_comb begin
    st_d  = st_q;
    k_d   = k_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (acc) begin
      if (k_q == KLAST) begin
        k_d        = '0;
        st_d[wr_q] = FULL;
        wr_d       = ~wr_q;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
    // acc needs wr bank FILLING and rel needs rd bank FULL, so they never hit the same bank
    if (rel) begin
      st_d[rd_q] = FILLING;
      rd_d       = ~rd_q;
      cnt_d      = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) st_q[b] <= FILLING;
      k_q   <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) st_q[b] <= st_d[b];
      k_q   <= k_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      en_q  <= 1'b1;
    end
  end

  // Bank contents need no reset: they are only visible while their bank is FULL
  always_ff @(posedge clk) begin
    if (acc) begin
      bank_q[wr_q][addr_x] <= in_x;
      bank_q[wr_q][addr_y] <= in_y;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_deser.sv
// Bench for fft_bitrev_deser: directed scenarios plus a randomized run against a
// frame-queue reference model; a second instance with a 4-bit frame counter covers wrap.
module tb_fft_bitrev_deser;
  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int SW    = 32;
  typedef logic [N-1:0][SW-1:0] frame_t;

  logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [SW-1:0] in_x = '0, in_y = '0;
  logic in_ready, out_valid, w_in_ready, w_out_valid;
  frame_t fft_out, w_fft_out;
  logic [15:0] frame_cnt;
  logic [3:0]  w_frame_cnt;

  always #5 clk = ~clk;

  fft_bitrev_deser #(.N(N), .DW(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .fft_out(fft_out), .frame_cnt(frame_cnt));

  fft_bitrev_deser #(.N(N), .DW(16), .FCW(4)) u_wrap (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(w_out_valid), .out_ready(out_ready),
    .fft_out(w_fft_out), .frame_cnt(w_frame_cnt));

  // Reference model: serial samples of the partial frame, queue of completed frames
  logic [SW-1:0] ser [N];
  frame_t        mq [$];
  int            mk;
  logic [15:0]   mcnt;
  bit            men;
  int            nvec = 0, nerr = 0;
  int            nat_exp [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int rev(input int s);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if ((s >> b) % 2 == 1) r += 1 << (LOG2N - 1 - b);
    return r;
  endfunction

  function automatic logic [SW-1:0] ord(input int s);
    logic [15:0] re, im;
    re = 16'(s);
    im = 16'(-s);
    return {re, im};
  endfunction

  function automatic frame_t exp_out();
    return (mq.size() > 0) ? mq[0] : '0;
  endfunction

  task automatic tick();
    bit acc, rel;
    frame_t f;
    acc = in_valid && men && (mq.size() < 2);
    rel = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (rel) begin
      void'(mq.pop_front());
      mcnt++;
    end
    if (acc) begin
      ser[2*mk]   = in_x;
      ser[2*mk+1] = in_y;
      mk++;
      if (mk == N / 2) begin
        for (int s = 0; s < N; s++) f[rev(s)] = ser[s];
        mq.push_back(f);
        mk = 0;
      end
    end
    men = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #2;
    mq.delete();
    mk = 0; mcnt = '0; men = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic send(input logic [SW-1:0] x, input logic [SW-1:0] y);
    in_x = x; in_y = y; in_valid = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1; reset_n = 1'b0;
    #13;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    nvec++; if (fft_out !== '0) begin nerr++; $display("FAIL reset_fft_out got %h want 0", fft_out); end
    nvec++; if (frame_cnt !== 16'd0) begin nerr++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    in_valid = 1'b0; out_ready = 1'b0;
    mq.delete(); mk = 0; mcnt = '0; men = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_release_ready got %b want 0", in_ready); end
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_first_cycle_ready got %b want 1", in_ready); end
  endtask

  task automatic test_order();
    do_reset();
    for (int p = 0; p < N / 2; p++) begin
      send(ord(2*p), ord(2*p+1));
      if (p == N / 2 - 2) begin
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL order_early_valid got %b want 0", out_valid); end
      end
    end
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL order_valid got %b want 1", out_valid); end
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (fft_out[i] !== ord(nat_exp[i])) begin
        nerr++; $display("FAIL order_fft_out[%0d] got %h want %h", i, fft_out[i], ord(nat_exp[i]));
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    nvec++; if (frame_cnt !== 16'd1 || out_valid !== 1'b0) begin
      nerr++; $display("FAIL order_release got cnt=%0d vld=%b want cnt=1 vld=0", frame_cnt, out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int p = 0; p < 3 * N / 2; p++) begin
      send($urandom, $urandom);
      if (p == N - 1) begin
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready_drop got %b want 0", in_ready); end
      end
    end
    nvec++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || fft_out !== exp_out()) begin
      nerr++; $display("FAIL bp_stall got rdy=%b vld=%b out=%h want rdy=0 vld=1 out=%h", in_ready, out_valid, fft_out, exp_out());
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || frame_cnt !== 16'd1 || fft_out !== exp_out()) begin
      nerr++; $display("FAIL bp_release got rdy=%b vld=%b cnt=%0d out=%h want 1 1 1 %h", in_ready, out_valid, frame_cnt, fft_out, exp_out());
    end
    for (int p = 0; p < N / 2; p++) send($urandom, $urandom);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      nvec++; if (fft_out !== exp_out() || frame_cnt !== mcnt) begin
        nerr++; $display("FAIL bp_drain got out=%h cnt=%0d want %h %0d", fft_out, frame_cnt, exp_out(), mcnt);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_gapped();
    int p = 0, c = 0;
    do_reset();
    while (p < N / 2) begin
      in_valid = (c % 3 == 0);
      in_x = ord(2*p); in_y = ord(2*p+1);
      tick();
      if (c % 3 == 0) p++;
      if (p < N / 2) begin
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL gap_early_valid c=%0d got %b want 0", c, out_valid); end
      end
      c++;
    end
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL gap_valid got %b want 1", out_valid); end
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (fft_out[i] !== ord(nat_exp[i])) begin
        nerr++; $display("FAIL gap_fft_out[%0d] got %h want %h", i, fft_out[i], ord(nat_exp[i]));
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int p = 0; p < N - 1; p++) send($urandom, $urandom);
    out_ready = 1'b1;
    send($urandom, $urandom);
    out_ready = 1'b0; in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1 || frame_cnt !== 16'd1 || in_ready !== 1'b1 || fft_out !== exp_out()) begin
      nerr++; $display("FAIL simul got vld=%b cnt=%0d rdy=%b out=%h want 1 1 1 %h", out_valid, frame_cnt, in_ready, fft_out, exp_out());
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send($urandom, $urandom);
    send($urandom, $urandom);
    in_valid = 1'b0;
    do_reset();
    for (int p = 0; p < N / 2; p++) send(ord(2*p), ord(2*p+1));
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (fft_out[i] !== ord(nat_exp[i])) begin
        nerr++; $display("FAIL rstmid_fft_out[%0d] got %h want %h", i, fft_out[i], ord(nat_exp[i]));
      end
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    nvec++; if (frame_cnt !== 16'd1) begin nerr++; $display("FAIL rstmid_cnt got %0d want 1", frame_cnt); end
    for (int c = 0; c < 6; c++) begin
      tick();
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rstmid_stray_valid got %b want 0", out_valid); end
    end
  endtask

  task automatic test_random();
    bit exp_rdy;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom % 4 != 0);
      out_ready = ($urandom % 3 == 0);
      in_x = $urandom; in_y = $urandom;
      tick();
      exp_rdy = men && (mq.size() < 2);
      nvec++;
      if (in_ready !== exp_rdy || out_valid !== (mq.size() > 0) || fft_out !== exp_out() || frame_cnt !== mcnt) begin
        nerr++;
        $display("FAIL rand c=%0d got rdy=%b vld=%b cnt=%0d out=%h want %b %b %0d %h",
                 c, in_ready, out_valid, frame_cnt, fft_out, exp_rdy, mq.size() > 0, mcnt, exp_out());
      end
      nvec++;
      if (w_frame_cnt !== mcnt[3:0] || w_in_ready !== exp_rdy || w_out_valid !== (mq.size() > 0) || w_fft_out !== exp_out()) begin
        nerr++;
        $display("FAIL wrap c=%0d got cnt=%0d rdy=%b vld=%b want cnt=%0d rdy=%b", c, w_frame_cnt, w_in_ready, w_out_valid, mcnt[3:0], exp_rdy);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_gapped();
    test_simultaneous();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_deser.md
Name: fft_bitrev_deser

Overview:
- Sits directly downstream of the radix-2 FFT pipeline (fft_N_rad2).
- Consumes the serial stream of complex results emitted two per cycle, in bit-reversed order.
- Deserializes each N-point frame into a natural-order parallel vector.
- Ping-pong double buffer: one frame can fill while the previous frame is held for the consumer, with a valid/ready handshake on both sides.

Parameters:
- N, 8, FFT size; power of two, at least 4.
- LOG2N, $clog2(N), address width.
- NUM_PAIRS, N/2, input beats per frame.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_x/in_y carry a valid sample pair.
- in_ready  output  1  block can accept a pair this cycle.
- in_x  input  complex_product_t  serial sample s=2k of the current frame.
- in_y  input  complex_product_t  serial sample s=2k+1 of the current frame.
- out_valid  output  1  fft_out holds a complete frame.
- out_ready  input  1  consumer takes the frame.
- fft_out  output  complex_product_t [N-1:0]  natural-order frame.
- frame_cnt  output  16  count of frames delivered; wraps.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, takes effect immediately):
  - in_ready=0, out_valid=0, fft_out all zero, frame_cnt=0.
  - Pair counter=0; wr_bank=0; rd_bank=0; both bank_full flags=0.
  - in_ready rises in the first cycle after reset_n deasserts.
- Storage: two banks, each N entries of complex_product_t. A bank_full flag per bank.
- in_ready = !bank_full[wr_bank]. It is driven from registered state only.
- Input accept: in_valid & in_ready at a rising edge.
  - Write in_x to bank[wr_bank][bitrev(2k)] and in_y to bank[wr_bank][bitrev(2k+1)].
  - k is the pair counter; bitrev is the LOG2N-bit reversal.
  - Then increment k.
- Frame completion: acceptance at k==NUM_PAIRS-1:
  - k wraps to 0.
  - bank_full[wr_bank] set.
  - wr_bank toggles.
- States per bank: FILLING (bank_full=0) and FULL (bank_full=1).
  - FILLING -> FULL on the last-pair accept.
  - FULL -> FILLING on the output handshake.
- out_valid = bank_full[rd_bank]. fft_out is driven from bank[rd_bank] and is stable while out_valid=1.
- Latency: out_valid is asserted in the cycle after the last pair is accepted, provided rd_bank points at that bank.
- Output handshake: out_valid & out_ready at a rising edge:
  - Clear bank_full[rd_bank].
  - rd_bank toggles.
  - frame_cnt increments, wrapping 0xFFFF->0.
- Simultaneous last-pair write and output release in the same cycle: both take effect.
  - The released bank becomes writable on the next cycle.
  - in_ready never combinationally depends on out_ready.
- Both banks FULL: in_ready=0. in_valid is ignored and k holds.
- in_valid low mid-frame: k holds; the frame resumes with no timeout.
- Reset mid-frame or with frames pending: the partial frame and all buffered frames are discarded. No out_valid pulse follows.
- Data values are passed unmodified: no scaling, rounding or saturation.

Test Plan:
- Order check (N=8): one frame with s=0..7, real=s, imag=-s.
  - Required: out_valid one cycle after the 4th pair.
  - fft_out[0..7] real = 0,4,2,6,1,5,3,7; imag is the negation of each.
- Backpressure: out_ready=0 while three frames are offered back to back.
  - First two frames are accepted; in_ready drops after the 8th pair; frame 3 stalls.
  - Raising out_ready for one cycle releases frame 1, shows frame 2 next cycle, and restores in_ready.
- Gapped input: in_valid toggles 1,0,0,1,... across a frame.
  - fft_out is identical to the order-check result; out_valid is 1 cycle after the last accepted pair.
- Simultaneous events: last pair of frame 2 is accepted in the same cycle as the out_ready release of frame 1.
  - Next cycle: out_valid=1 with frame 2 data and frame_cnt=1.
- Reset mid-frame: reset_n=0 after 2 pairs, then a full new frame is sent.
  - Only the new frame appears, natural order correct, frame_cnt=1 after its handshake.
- Wrap: 65536 frames are delivered.
  - frame_cnt returns to 0; the pair counter and bank pointers have no off-by-one.
